// File: rtl/cpu_pkg.sv
// Shared SimpleCPU definitions: datapath widths, special opcodes and the
// fetch-stage state encoding.
package cpu_pkg;

    localparam int PC_W  = 8;
    localparam int INS_W = 16;

    localparam logic [3:0]       OPC_HALT = 4'hF;
    localparam logic [INS_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_HOLD = 2'd2,
        F_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory handshake, pipeline control
// inputs and the IF/ID register outputs.
interface fetch_unit_if #(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int INS_W = cpu_pkg::INS_W
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic [INS_W-1:0] imem_rdata;
    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [INS_W-1:0] ins_out;
    logic             ins_we;
    logic [PC_W-1:0]  pc_out;
    logic             halted;

    modport master (
        output imem_req, imem_addr, ins_out, ins_we, pc_out, halted,
        input  imem_ready, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ins_out, ins_we, pc_out, halted,
        output imem_ready, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem request/ready handshake
// and feeds the IF/ID register, with stall buffering, redirects and HALT.
//
// state  | meaning
// F_IDLE | one cycle after reset release, no request
// F_REQ  | imem_req=1 at pc, waiting for imem_ready
// F_HOLD | fetched word parked in hold buffer while decode stalls
// F_HALT | HALT opcode delivered; fetch stopped until redirect
module fetch_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_pc_out;
    logic [INS_W-1:0] r_hold;
    logic [INS_W-1:0] r_ins;
    logic             r_we;

    logic             w_rdata_halt;
    logic             w_hold_halt;

    assign w_rdata_halt = (bus.imem_rdata[INS_W-1 -: 4] == OPC_HALT);
    assign w_hold_halt  = (r_hold[INS_W-1 -: 4] == OPC_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= F_IDLE;
            r_pc     <= '0;
            r_pc_out <= '0;
            r_hold   <= NOP_WORD;
            r_ins    <= NOP_WORD;
            r_we     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // A redirect wins over everything, including a response landing this cycle.
            if (bus.redirect) begin
                r_pc    <= bus.redirect_pc;
                r_hold  <= NOP_WORD;
                r_state <= F_REQ;
            end else begin
                case (r_state)
                    F_IDLE: r_state <= F_REQ;
                    F_REQ: begin
                        if (bus.imem_ready) begin
                            r_pc_out <= r_pc;
                            r_pc     <= r_pc + 1'b1;
                            if (bus.stall) begin
                                r_hold  <= bus.imem_rdata;
                                r_state <= F_HOLD;
                            end else begin
                                r_ins   <= bus.imem_rdata;
                                r_we    <= 1'b1;
                                r_state <= w_rdata_halt ? F_HALT : F_REQ;
                            end
                        end
                    end
                    F_HOLD: begin
                        if (!bus.stall) begin
                            r_ins   <= r_hold;
                            r_we    <= 1'b1;
                            r_state <= w_hold_halt ? F_HALT : F_REQ;
                        end
                    end
                    F_HALT: r_state <= F_HALT;
                    default: r_state <= F_IDLE;
                endcase
            end
        end
    end

    assign bus.imem_req  = (r_state == F_REQ);
    assign bus.imem_addr = r_pc;
    assign bus.ins_out   = r_ins;
    assign bus.ins_we    = r_we;
    assign bus.pc_out    = r_pc_out;
    assign bus.halted    = (r_state == F_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, directed corner
// sequences, and a memory-model scoreboard checking every delivered word.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_rdy = 1'b0;
    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_ready = r_rdy;
    assign bus.imem_rdata = mem[bus.imem_addr];

    typedef struct packed {
        logic [15:0] ins;
        logic [7:0]  pc;
    } sb_entry_t;

    sb_entry_t sb[$];

    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.ins_we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got ins=%h pc=%h, required no delivery",
                             bus.ins_out, bus.pc_out);
                end else begin
                    e = sb.pop_front();
                    if (bus.ins_out !== e.ins || bus.pc_out !== e.pc) begin
                        errors++;
                        $display("FAIL sb_delivery: got ins=%h pc=%h, required ins=%h pc=%h",
                                 bus.ins_out, bus.pc_out, e.ins, e.pc);
                    end
                end
            end
            if (bus.imem_req && bus.imem_ready && !bus.redirect)
                sb.push_back('{mem[bus.imem_addr], bus.imem_addr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r_rdy = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        redir;
        logic [7:0]  rpc;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_we;
        logic [15:0] e_ins;
        logic [7:0]  e_pc;
        logic        e_halt;
    } vec_t;

    vec_t tbl [13];
    logic [7:0] wrap_exp [3];
    logic [7:0] wrap_got [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

        //          rdy   stall redir rpc     req   addr   we    ins       pc     halt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 16'h1000, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'h1001, 8'h01, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 16'h1002, 8'h02, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 16'h1003, 8'h03, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 16'h1003, 8'h04, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 16'h1003, 8'h04, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 16'h1004, 8'h04, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 16'h1005, 8'h05, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 16'h1005, 8'h05, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 16'h1006, 8'h06, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 16'h1006, 8'h06, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 16'h1040, 8'h40, 1'b0};

        wrap_exp[0] = 8'hFE;
        wrap_exp[1] = 8'hFF;
        wrap_exp[2] = 8'h00;

        // Reset values and the vector table: streaming, stall/hold, redirect.
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_state", {bus.imem_req, bus.imem_addr, bus.ins_we, bus.ins_out, bus.pc_out, bus.halted},
            {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0});
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            r_rdy = tbl[i].rdy;
            bus.stall = tbl[i].stall;
            bus.redirect = tbl[i].redir;
            bus.redirect_pc = tbl[i].rpc;
            step();
            chk($sformatf("vec%0d", i),
                {bus.imem_req, bus.imem_addr, bus.ins_we, bus.ins_out, bus.pc_out, bus.halted},
                {tbl[i].e_req, tbl[i].e_addr, tbl[i].e_we, tbl[i].e_ins, tbl[i].e_pc, tbl[i].e_halt});
        end
        r_rdy = 1'b0;
        bus.redirect = 1'b0;

        // imem_ready delayed three cycles on address 0.
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wait_req_held", {bus.imem_req, bus.imem_addr, bus.ins_we}, {1'b1, 8'h00, 1'b0});
            step();
        end
        r_rdy = 1'b1;
        step();
        r_rdy = 1'b0;
        chk("wait_delivery", {bus.ins_we, bus.ins_out, bus.pc_out, bus.imem_addr},
            {1'b1, 16'h1000, 8'h00, 8'h01});
        step();
        chk("wait_single_pulse", {63'd0, bus.ins_we}, 64'd0);

        // HALT at address 3, then redirect out of F_HALT.
        mem[3] = 16'hF000;
        do_reset();
        r_rdy = 1'b1;
        for (int i = 0; i < 20 && !bus.halted; i++) step();
        chk("halt_reached", {63'd0, bus.halted}, 64'd1);
        chk("halt_word", {bus.ins_we, bus.ins_out, bus.pc_out}, {1'b1, 16'hF000, 8'h03});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_idle", {bus.imem_req, bus.halted, bus.ins_we}, {1'b0, 1'b1, 1'b0});
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h10;
        step();
        bus.redirect = 1'b0;
        chk("halt_redirect", {bus.halted, bus.imem_req, bus.imem_addr, bus.ins_we},
            {1'b0, 1'b1, 8'h10, 1'b0});
        step();
        chk("halt_resume", {bus.ins_we, bus.ins_out, bus.pc_out}, {1'b1, 16'h1010, 8'h10});
        r_rdy = 1'b0;
        mem[3] = 16'h1003;

        // PC wrap from FE, then asynchronous reset mid-fetch.
        do_reset();
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'hFE;
        step();
        bus.redirect = 1'b0;
        chk("wrap_redirect_addr", {56'd0, bus.imem_addr}, {56'd0, 8'hFE});
        r_rdy = 1'b1;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 20 && n < 3; i++) begin
                step();
                if (bus.ins_we) begin
                    wrap_got[n] = bus.pc_out;
                    n++;
                end
            end
            chk("wrap_count", 64'(n), 64'd3);
            for (int i = 0; i < 3; i++)
                chk($sformatf("wrap_pc%0d", i), {56'd0, wrap_got[i]}, {56'd0, wrap_exp[i]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.imem_req, bus.imem_addr, bus.ins_we, bus.ins_out, bus.pc_out, bus.halted},
            {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0});
        r_rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the SimpleCPU pipeline. It keeps the program counter and requests 16-bit instructions from instruction memory through a request/ready handshake. Each fetched instruction is delivered to the IF/ID pipeline register as a data word plus a one-cycle write-enable pulse. The block also handles pipeline stalls, branch/jump redirects and a HALT opcode.

## Interface
- PC_W, 8, program counter / instruction address width
- INS_W, 16, instruction width; opcode is bits [INS_W-1:INS_W-4]
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  address of requested instruction (= pc)
- imem_ready  in  1  memory response valid; meaningful only while imem_req=1
- imem_rdata  in  INS_W  instruction word, valid when imem_ready=1
- stall  in  1  downstream (decode) cannot accept an instruction this cycle
- redirect  in  1  branch/jump taken; load new PC
- redirect_pc  in  PC_W  target address, sampled when redirect=1
- ins_out  out  INS_W  instruction to IF/ID register
- ins_we  out  1  one-cycle pulse: ins_out is a new instruction
- pc_out  out  PC_W  address of the instruction on ins_out
- halted  out  1  fetch stopped by HALT opcode

## Operation
- Reset values (async): pc=0, state F_IDLE, imem_req=0, imem_addr=0, ins_out=16'h0000 (NOP), ins_we=0, pc_out=0, halted=0, hold buffer cleared.
- F_IDLE: unconditional → F_REQ on the first clock after reset release.
- F_REQ: imem_req=1 with imem_addr=pc held stable until imem_ready=1.
  - imem_ready=1 and stall=0: ins_out←imem_rdata, pc_out←pc, ins_we←1, pc←pc+1; remain in F_REQ (back-to-back fetch).
  - imem_ready=1 and stall=1: word goes into the hold buffer, pc_out←pc, pc←pc+1, → F_HOLD, imem_req=0.
- F_HOLD: imem_req=0. When stall=0: ins_out←hold buffer, ins_we←1, → F_REQ.
- HALT: a delivered instruction whose opcode is 4'hF goes out normally with ins_we=1. Next state is then F_HALT instead of F_REQ. A HALT caught in F_HOLD is delivered first, then → F_HALT.
- F_HALT: imem_req=0, halted=1, ins_we=0. Only redirect or reset leaves this state.
- Redirect (highest priority, any state): pc←redirect_pc, hold buffer discarded, ins_we=0 that cycle, halted←0, → F_REQ. A response arriving in the same cycle (imem_ready=1) is dropped. Abandoning an outstanding request is legal; memory ignores it.
- PC arithmetic: pc+1 wraps modulo 2^PC_W (8'hFF → 8'h00). No fault is raised.
- ins_out holds its last value while ins_we=0.

## Timing
- Latency: imem_ready sampled at edge N → ins_out/ins_we valid after edge N (one registered stage).
- Throughput with imem_ready tied 1 and stall=0: one instruction per cycle.
- Reset release → first imem_req=1: one cycle (F_IDLE). With imem_ready=1, the first ins_we follows one cycle later.
- stall deasserted at edge N in F_HOLD → buffered ins_we=1 after edge N. The new request issues the cycle after.
- redirect at edge N → imem_addr=redirect_pc after edge N.
- rst_n asserted mid-operation: all outputs go to reset values immediately (asynchronous), and any in-flight request is abandoned.

## Structure
- Shared package cpu_pkg: OPC_HALT=4'hF, INS_W and PC_W defaults, NOP word 16'h0000, and the state enum fetch_state_t {F_IDLE, F_REQ, F_HOLD, F_HALT}.
- Single module; no sub-module. The PC register, hold buffer and FSM are small enough to stay together.

## Test plan
- Reset, imem_ready=1, memory[i]=16'h1000+i, stall=0 → ins_we high every cycle from cycle 2 onward; ins_out=1000,1001,1002; pc_out=0,1,2.
- imem_ready delayed 3 cycles on address 0 → imem_addr stays 0 with imem_req=1 throughout; one ins_we pulse with ins_out=16'h1000.
- stall=1 while imem_ready=1 at pc=4 → F_HOLD with imem_req=0. Release stall 2 cycles later → ins_out=16'h1004, pc_out=4, then fetch resumes at 5.
- redirect=1, redirect_pc=8'h40 coinciding with imem_ready on pc=7 → no ins_we that cycle; next imem_addr=8'h40; the next delivered pc_out is 8'h40.
- memory[3]=16'hF000 → HALT word delivered with ins_we=1, then halted=1 and imem_req=0 indefinitely. redirect to 8'h10 → halted=0 and fetch resumes at 8'h10.
- pc starts at 8'hFE via redirect → pc_out sequence FE, FF, 00. Assert rst_n=0 mid-fetch → outputs reset asynchronously without waiting for a clock edge.
